// File: rtl/tgl_handshake_rx.sv
// tgl_handshake_rx: receiving end of a 2-phase toggle handshake.
//
// The sender toggles req_tgl once per word and holds req_data stable until it
// sees ack_tgl match. This block synchronises req_tgl, captures the word into a
// holding register, offers it on a valid/ready port, and toggles ack_tgl once
// the consumer takes it. It also counts completed transfers.
//
// Ports:
//   clk        clock; all state updates on posedge
//   reset      synchronous, active-high
//   req_tgl    request toggle from sender (may be asynchronous to clk)
//   req_data   payload, stable while req_tgl != ack_tgl
//   ack_tgl    registered acknowledge toggle back to sender
//   out_data   captured payload, meaningful while out_valid=1
//   out_valid  word available to consumer
//   out_ready  consumer accepts when out_valid & out_ready
//   xfer_cnt   completed transfers, wraps modulo 2^CNT_W
//   proto_err  sticky: req toggled again while a word was still unacknowledged
module tgl_handshake_rx #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_tgl,
    input  logic [DATA_W-1:0] req_data,
    output logic              ack_tgl,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic              proto_err
);

    // One-hot encoding leaves two unused codes; both fall back to idle.
    typedef enum logic [1:0] {
        StIdle = 2'b01,
        StHold = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                req_s;
    logic                req_s_prev_q;
    logic                ack_q, ack_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                pend;

    assign req_s = sync_q[SYNC_STAGES-1];
    assign pend  = (req_s != ack_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= '0;
            req_s_prev_q <= 1'b0;
            state_q      <= StIdle;
            ack_q        <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], req_tgl};
            req_s_prev_q <= req_s;
            state_q      <= state_d;
            ack_q        <= ack_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                valid_d = 1'b0;
                if (pend) begin
                    // req_data is already stable: the sender set it before toggling.
                    data_d  = req_data;
                    valid_d = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                valid_d = 1'b1;
                // Any edge on req_s here means the sender did not wait for our ack.
                if (req_s != req_s_prev_q) begin
                    err_d = 1'b1;
                end
                if (out_ready) begin
                    valid_d = 1'b0;
                    ack_d   = ~ack_q;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = StIdle;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    assign ack_tgl   = ack_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign xfer_cnt  = cnt_q;
    assign proto_err = err_q;

endmodule

// File: tb/tb_tgl_handshake_rx.sv
// Self-checking bench for tgl_handshake_rx (SYNC_STAGES=2, DATA_W=8, CNT_W=8).
// A cycle table covers reset, a single transfer and backpressure; hand-written
// sequences cover the 256-word stream, protocol error and reset mid-transfer.
module tb_tgl_handshake_rx;

    logic       clk;
    logic       reset;
    logic       req_tgl;
    logic [7:0] req_data;
    logic       ack_tgl;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] xfer_cnt;
    logic       proto_err;

    int n_vec = 0;
    int n_err = 0;

    tgl_handshake_rx #(
        .DATA_W      (8),
        .SYNC_STAGES (2),
        .CNT_W       (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_tgl   (req_tgl),
        .req_data  (req_data),
        .ack_tgl   (ack_tgl),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic       rst;
        logic       tgl;
        logic [7:0] data;
        logic       rdy;
        logic       e_ack;
        logic       e_valid;
        logic [7:0] e_data;
        logic       chk_data;
        logic [7:0] e_cnt;
        logic       e_err;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int lim, input string nm);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < lim) begin
            step();
            n++;
        end
        chk(nm, 32'(out_valid), 32'd1);
    endtask

    task automatic wait_ack(input int lim, input string nm);
        int n;
        n = 0;
        while (ack_tgl !== req_tgl && n < lim) begin
            step();
            n++;
        end
        chk(nm, 32'(ack_tgl), 32'(req_tgl));
    endtask

    logic [7:0] exp_cnt;

    initial begin
        reset     = 1'b1;
        req_tgl   = 1'b0;
        req_data  = 8'h00;
        out_ready = 1'b0;

        //            rst   tgl   data   rdy   ack   vld   odata  chkd  cnt    err
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'd0, 1'b0};
        // single transfer: req_s rises after 2nd edge, valid after 3rd, accept on 4th
        vecs[2]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 8'd0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd1, 1'b0};
        // backpressure with 8'h3C
        vecs[7]  = '{1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'd1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'd1, 1'b0};
        for (int i = 9; i <= 14; i++) begin
            vecs[i] = '{1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 8'd1, 1'b0};
        end
        vecs[15] = '{1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'd2, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'd2, 1'b0};

        #2;
        for (int i = 0; i < NVEC; i++) begin
            reset     = vecs[i].rst;
            req_tgl   = vecs[i].tgl;
            req_data  = vecs[i].data;
            out_ready = vecs[i].rdy;
            step();
            chk($sformatf("v%0d.ack", i), 32'(ack_tgl), 32'(vecs[i].e_ack));
            chk($sformatf("v%0d.valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
            if (vecs[i].chk_data) begin
                chk($sformatf("v%0d.data", i), 32'(out_data), 32'(vecs[i].e_data));
            end
            chk($sformatf("v%0d.cnt", i), 32'(xfer_cnt), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d.err", i), 32'(proto_err), 32'(vecs[i].e_err));
        end

        // 256 back-to-back words from a clean reset; counter must wrap to 0.
        reset   = 1'b1;
        req_tgl = 1'b0;
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        exp_cnt   = 8'd0;
        for (int w = 0; w < 256; w++) begin
            req_data = 8'(w);
            req_tgl  = ~req_tgl;
            wait_valid(8, $sformatf("b2b%0d.valid", w));
            chk($sformatf("b2b%0d.data", w), 32'(out_data), 32'(w));
            wait_ack(4, $sformatf("b2b%0d.ack", w));
            exp_cnt = exp_cnt + 8'd1;
            chk($sformatf("b2b%0d.cnt", w), 32'(xfer_cnt), 32'(exp_cnt));
        end
        chk("b2b.cnt_wrapped", 32'(xfer_cnt), 32'd0);
        chk("b2b.ack_eq_req", 32'(ack_tgl), 32'(req_tgl));
        chk("b2b.err", 32'(proto_err), 32'd0);

        // Protocol error: two extra toggles while holding 8'h5A.
        out_ready = 1'b0;
        req_data  = 8'h5A;
        req_tgl   = 1'b1;
        wait_valid(8, "perr.valid");
        chk("perr.data", 32'(out_data), 32'h5A);
        chk("perr.err_before", 32'(proto_err), 32'd0);
        req_tgl = 1'b0;
        repeat (3) step();
        chk("perr.err_first", 32'(proto_err), 32'd1);
        chk("perr.data_kept", 32'(out_data), 32'h5A);
        chk("perr.valid_kept", 32'(out_valid), 32'd1);
        chk("perr.no_ack", 32'(ack_tgl), 32'd0);
        req_tgl = 1'b1;
        repeat (3) step();
        chk("perr.err_second", 32'(proto_err), 32'd1);
        chk("perr.data_kept2", 32'(out_data), 32'h5A);
        out_ready = 1'b1;
        step();
        chk("perr.ack", 32'(ack_tgl), 32'd1);
        chk("perr.valid_drop", 32'(out_valid), 32'd0);
        chk("perr.cnt", 32'(xfer_cnt), 32'd1);
        repeat (3) step();
        chk("perr.err_sticky", 32'(proto_err), 32'd1);
        chk("perr.idle", 32'(out_valid), 32'd0);

        // Reset while holding 8'h77: word dropped, no ack toggle.
        out_ready = 1'b0;
        req_data  = 8'h77;
        req_tgl   = 1'b0;
        wait_valid(8, "rst.valid");
        chk("rst.data_before", 32'(out_data), 32'h77);
        chk("rst.ack_before", 32'(ack_tgl), 32'd1);
        reset = 1'b1;
        step();
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.ack", 32'(ack_tgl), 32'd0);
        chk("rst.cnt", 32'(xfer_cnt), 32'd0);
        chk("rst.err", 32'(proto_err), 32'd0);
        chk("rst.data", 32'(out_data), 32'h00);
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        chk("rst.ack_after", 32'(ack_tgl), 32'd0);
        chk("rst.valid_after", 32'(out_valid), 32'd0);
        chk("rst.cnt_after", 32'(xfer_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
